td4_sequencer: RTL and testbench
================================

Name: td4_sequencer

Overview:
- Run/step/halt controller for the TD4 core.
- Generates the single-cycle execute strobe that gates every architectural register load (A, B, C, PC) chosen by the opcode decoder.
- Waits out program-ROM read latency and optionally throttles execution rate.
- Stops on debugger halt, PC breakpoint, or a detected "JMP to self" program end.

Parameters:
- ROM_LATENCY, 1, cycles from pc change to op/imm valid; legal range 1..3.
- DIV_WIDTH, 24, width of the run-rate divider input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- run_req  in  1  level; free-run while high
- step_req  in  1  pulse; execute exactly one instruction from halt
- halt_req  in  1  pulse; stop at next instruction boundary
- bp_en  in  1  breakpoint enable
- bp_addr  in  4  breakpoint PC
- div_sel  in  DIV_WIDTH  idle cycles inserted after each executed instruction in run mode; 0 = none
- pc  in  4  current core PC
- op  in  4  opcode from ROM
- imm  in  4  immediate from ROM
- exec_en  out  1  one-cycle strobe; the core loads the decoded destination on this cycle
- seq_state  out  2  current state encoding
- halted  out  1  high in IDLE
- loop_halt  out  1  sticky; set when halted by JMP-to-self
- instr_count  out  16  executed-instruction counter

Behaviour:
- States: IDLE=0, FETCH=1, EXEC=2, WAIT=3.
- Reset (synchronous, rst high at a clk edge): state IDLE, exec_en 0, halted 1, loop_halt 0, instr_count 0, timer 0, resume flag 0. Reset mid-instruction aborts with no exec_en.
- Priority: rst > halt_req > breakpoint > step_req / run_req.
- IDLE:
  - step_req → FETCH, mode STEP. Otherwise run_req → FETCH, mode RUN.
  - Either transition sets resume=1 and clears loop_halt.
  - halt_req in IDLE is a no-op.
- FETCH:
  - Loads the timer with ROM_LATENCY-1 on entry and counts down.
  - When the timer reaches 0, op/imm are valid.
  - If bp_en, pc==bp_addr and resume==0 → IDLE with no exec. Otherwise → EXEC.
  - resume clears on leaving FETCH.
  - halt_req during FETCH → IDLE immediately, no exec.
- EXEC:
  - Exactly one cycle. exec_en=1 and instr_count+1; the counter wraps 16'hFFFF→0.
  - EXEC cannot be aborted by halt_req; the halt takes effect on exit.
  - Exit:
    - If op==4'b1111 (JMP imm) and imm==pc → IDLE, loop_halt=1.
    - Else if mode STEP, or halt_req seen in EXEC, or run_req low → IDLE.
    - Else if div_sel==0 → FETCH.
    - Else → WAIT, with the timer loaded to div_sel-1.
- WAIT:
  - Counts down; at 0 → FETCH.
  - halt_req or run_req low → IDLE.
- Fetch latency: first exec_en occurs ROM_LATENCY+1 cycles after the IDLE exit edge.
- Steady run with div_sel=0: one instruction per ROM_LATENCY+1 cycles.
- Steady run with div_sel=N: one instruction per ROM_LATENCY+1+N cycles.
- JNC not taken still produces exec_en; the decoder's don't-care load pattern is the core's concern, and the PC increments on exec_en.
- step_req and run_req together in IDLE: step wins, one instruction only.
- exec_en is never asserted in two consecutive cycles.
- halted is 1 exactly when state==IDLE.
- All outputs are registered.

Decomposition:
- td4_pkg: opcode constants (JMP_IM=4'b1111, JNC_IM=4'b1110 and the rest of the ISA table), seq_state_t enum {IDLE, FETCH, EXEC, WAIT}, run-mode enum {STEP, RUN}.
- Sub-module td4_seq_timer: loadable DIV_WIDTH down-counter with load, value, and zero flag. It is shared by the FETCH latency and WAIT divider, since the two phases never overlap.

Test Plan:
- Reset then step_req pulse, ROM_LATENCY=1, pc=0, op=4'b0011 → exec_en exactly once, 2 cycles after step; back to IDLE; instr_count=1.
- run_req held, div_sel=0, ROM_LATENCY=2, program without self-loop → exec_en every 3rd cycle; instr_count=10 after 30 cycles.
- run_req held, div_sel=5 → exec_en period 2+5 cycles with ROM_LATENCY=1. Drop run_req in WAIT → IDLE next cycle, no further exec_en.
- bp_en=1, bp_addr=4'h3, run from pc=0 → halts before executing pc=3, instr_count=3. step_req then executes pc=3 (resume skips breakpoint) and returns to IDLE.
- Program reaches op=4'b1111, imm=4'h5 at pc=5 → one exec_en, then IDLE with loop_halt=1. The next run_req clears loop_halt.
- halt_req in FETCH → IDLE with no exec_en. halt_req coincident with EXEC → that exec_en still fires, then IDLE. rst asserted during WAIT → all outputs at reset values next cycle. instr_count preset near 16'hFFFF wraps to 0.

Source files
------------

// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - TD4 opcode table and sequencer state/mode types
package td4_pkg;

    localparam logic [3:0] ADD_A_IM = 4'b0000;
    localparam logic [3:0] MOV_A_B  = 4'b0001;
    localparam logic [3:0] IN_A     = 4'b0010;
    localparam logic [3:0] MOV_A_IM = 4'b0011;
    localparam logic [3:0] MOV_B_A  = 4'b0100;
    localparam logic [3:0] ADD_B_IM = 4'b0101;
    localparam logic [3:0] IN_B     = 4'b0110;
    localparam logic [3:0] MOV_B_IM = 4'b0111;
    localparam logic [3:0] OUT_B    = 4'b1001;
    localparam logic [3:0] OUT_IM   = 4'b1011;
    localparam logic [3:0] JNC_IM   = 4'b1110;
    localparam logic [3:0] JMP_IM   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WAIT  = 2'd3
    } seq_state_t;

    typedef enum logic {
        STEP = 1'b0,
        RUN  = 1'b1
    } run_mode_t;

endpackage

// File: rtl/td4_seq_timer.sv
// rtl/td4_seq_timer.sv - loadable down-counter shared by fetch latency and run divider
module td4_seq_timer #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/td4_sequencer.sv
// rtl/td4_sequencer.sv - run/step/halt controller producing the TD4 execute strobe
module td4_sequencer
    import td4_pkg::*;
#(
    parameter int ROM_LATENCY = 1,
    parameter int DIV_WIDTH   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 halt_req,
    input  logic                 bp_en,
    input  logic [3:0]           bp_addr,
    input  logic [DIV_WIDTH-1:0] div_sel,
    input  logic [3:0]           pc,
    input  logic [3:0]           op,
    input  logic [3:0]           imm,
    output logic                 exec_en,
    output logic [1:0]           seq_state,
    output logic                 halted,
    output logic                 loop_halt,
    output logic [15:0]          instr_count
);

    localparam logic [DIV_WIDTH-1:0] FETCH_LOAD = DIV_WIDTH'(ROM_LATENCY - 1);

    seq_state_t           state, next_state;
    run_mode_t            mode;
    logic                 resume;
    logic [15:0]          count_q;
    logic                 tmr_load;
    logic [DIV_WIDTH-1:0] tmr_value;
    logic                 tmr_zero;
    logic                 bp_hit;
    logic                 self_jump;

    assign bp_hit      = bp_en && (pc == bp_addr);
    assign self_jump   = (op == JMP_IM) && (imm == pc);
    assign instr_count = count_q;

    td4_seq_timer #(.WIDTH(DIV_WIDTH)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= STEP;
            resume    <= 1'b0;
            exec_en   <= 1'b0;
            seq_state <= IDLE;
            halted    <= 1'b1;
            loop_halt <= 1'b0;
            count_q   <= 16'h0000;
        end else begin
            state     <= next_state;
            exec_en   <= (next_state == EXEC);
            seq_state <= next_state;
            halted    <= (next_state == IDLE);
            if (state == IDLE && next_state == FETCH) begin
                mode      <= step_req ? STEP : RUN;
                resume    <= 1'b1;
                loop_halt <= 1'b0;
            end
            if (state == FETCH && next_state != FETCH) begin
                resume <= 1'b0;
            end
            if (state == EXEC && self_jump) begin
                loop_halt <= 1'b1;
            end
            if (next_state == EXEC) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!halt_req && (step_req || run_req)) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (halt_req) begin
                    next_state = IDLE;
                end else if (tmr_zero) begin
                    // A resumed fetch steps over the breakpoint it stopped on.
                    next_state = (bp_hit && !resume) ? IDLE : EXEC;
                end
            end
            EXEC: begin
                if (self_jump || mode == STEP || halt_req || !run_req) begin
                    next_state = IDLE;
                end else if (div_sel == '0) begin
                    next_state = FETCH;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (halt_req || !run_req) begin
                    next_state = IDLE;
                end else if (tmr_zero) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (next_state == FETCH && state != FETCH) begin
            tmr_load  = 1'b1;
            tmr_value = FETCH_LOAD;
        end else if (state == EXEC && next_state == WAIT) begin
            tmr_load  = 1'b1;
            tmr_value = div_sel - DIV_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_td4_sequencer.sv
// tb/tb_td4_sequencer.sv - directed/random bench for td4_sequencer at ROM_LATENCY 1 and 2
module tb_td4_sequencer;
    import td4_pkg::*;

    logic        clk = 1'b0;
    logic        rst, step_req, halt_req, bp_en, run1, run2;
    logic [3:0]  bp_addr;
    logic [23:0] div_sel;
    logic [3:0]  pc1, pc2, op1, op2, imm1, imm2;
    logic        exec1, exec2, halted1, halted2, loop1, loop2;
    logic [1:0]  state1, state2;
    logic [15:0] count1, count2;
    logic [3:0]  rom_op [16];
    logic [3:0]  rom_imm [16];
    logic        prev1 = 1'b0, prev2 = 1'b0;
    int          cyc = 0, n_assert = 0, n_fail = 0, consec = 0;
    int          q1[$], q2[$], p1[$], p2[$];
    int          c0, nd, t1, t2;

    always #5 clk = ~clk;

    assign op1  = rom_op[pc1];
    assign imm1 = rom_imm[pc1];
    assign op2  = rom_op[pc2];
    assign imm2 = rom_imm[pc2];

    td4_sequencer #(.ROM_LATENCY(1), .DIV_WIDTH(24)) u_d1 (
        .clk(clk), .rst(rst), .run_req(run1), .step_req(step_req), .halt_req(halt_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .div_sel(div_sel), .pc(pc1), .op(op1), .imm(imm1),
        .exec_en(exec1), .seq_state(state1), .halted(halted1), .loop_halt(loop1),
        .instr_count(count1)
    );

    td4_sequencer #(.ROM_LATENCY(2), .DIV_WIDTH(24)) u_d2 (
        .clk(clk), .rst(rst), .run_req(run2), .step_req(step_req), .halt_req(halt_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .div_sel(div_sel), .pc(pc2), .op(op2), .imm(imm2),
        .exec_en(exec2), .seq_state(state2), .halted(halted2), .loop_halt(loop2),
        .instr_count(count2)
    );

    // Core model: PC advances (or jumps) on each execute strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) pc1 <= 4'd0;
        else if (exec1) pc1 <= (op1 == JMP_IM) ? imm1 : pc1 + 4'd1;
        if (rst) pc2 <= 4'd0;
        else if (exec2) pc2 <= (op2 == JMP_IM) ? imm2 : pc2 + 4'd1;
    end

    always @(negedge clk) begin
        if (exec1) begin q1.push_back(cyc); p1.push_back(int'(pc1)); end
        if (exec2) begin q2.push_back(cyc); p2.push_back(int'(pc2)); end
        if ((exec1 && prev1) || (exec2 && prev2)) consec <= consec + 1;
        prev1 <= exec1;
        prev2 <= exec2;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Execute strobes must land on first, first+period, ... exactly n times.
    task automatic sched(input int q[$], input int first, input int period, input int n,
                         input string tag);
        chk({tag, "_n"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < q.size() && i < n; i++)
            chk(tag, 32'(q[i]), 32'(first + i * period));
    endtask

    task automatic do_reset();
        rst = 1'b1; run1 = 1'b0; run2 = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = 4'd0; div_sel = 24'd0;
        tick(2);
        rst = 1'b0;
        q1.delete(); q2.delete(); p1.delete(); p2.delete();
        tick(1);
    endtask

    task automatic fill_prog();
        for (int i = 0; i < 16; i++) begin
            rom_op[i]  = 4'($urandom_range(0, 13));
            rom_imm[i] = 4'($urandom);
        end
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(6);
    endtask

    // Debugger behaviour: release run once the sequencer reports halted.
    task automatic run_to_halt(input int max);
        run1 = 1'b1; run2 = 1'b1;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (run1 && halted1) run1 = 1'b0;
            if (run2 && halted2) run2 = 1'b0;
            if (!run1 && !run2) break;
        end
        chk("run_bound", 32'({run1, run2}), 32'd0);
        run1 = 1'b0; run2 = 1'b0;
        tick(2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin rom_op[i] = MOV_A_IM; rom_imm[i] = 4'($urandom); end
        do_reset();
        chk("rst_exec1", 32'(exec1), 32'd0);   chk("rst_exec2", 32'(exec2), 32'd0);
        chk("rst_halt1", 32'(halted1), 32'd1); chk("rst_halt2", 32'(halted2), 32'd1);
        chk("rst_state1", 32'(state1), 32'd0); chk("rst_loop1", 32'(loop1), 32'd0);
        chk("rst_count1", 32'(count1), 32'd0); chk("rst_count2", 32'(count2), 32'd0);

        // single step
        c0 = cyc;
        step_req = 1'b1;
        tick(1);
        chk("step_fetch1", 32'(state1), 32'd1);
        step_req = 1'b0;
        tick(8);
        sched(q1, c0 + 2, 2, 1, "step_d1");
        sched(q2, c0 + 3, 3, 1, "step_d2");
        chk("step_count1", 32'(count1), 32'd1); chk("step_count2", 32'(count2), 32'd1);
        chk("step_idle1", 32'(halted1), 32'd1); chk("step_pc1", 32'(pc1), 32'd1);

        // free run, no divider
        do_reset(); fill_prog();
        c0 = cyc; run1 = 1'b1; run2 = 1'b1;
        tick(30);
        chk("run_count2", 32'(count2), 32'd10);
        chk("run_count1", 32'(count1), 32'd15);
        run1 = 1'b0; run2 = 1'b0;
        tick(6);
        sched(q2, c0 + 3, 3, 10, "run_d2");
        sched(q1, c0 + 2, 2, 15, "run_d1");

        // free run with random divider, drop run in WAIT
        do_reset(); fill_prog();
        nd = int'($urandom_range(2, 5));
        div_sel = 24'(nd);
        c0 = cyc; run1 = 1'b1; run2 = 1'b1;
        t1 = c0 + 2 + 2 * (2 + nd);
        t2 = c0 + 3 + 2 * (3 + nd);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (cyc == t1 + 1) begin chk("div_wait1", 32'(state1), 32'd3); run1 = 1'b0; end
            if (cyc == t1 + 2) chk("div_idle1", 32'(halted1), 32'd1);
            if (cyc == t2 + 1) begin chk("div_wait2", 32'(state2), 32'd3); run2 = 1'b0; end
            if (cyc == t2 + 2) chk("div_idle2", 32'(halted2), 32'd1);
        end
        sched(q1, c0 + 2, 2 + nd, 3, "div_d1");
        sched(q2, c0 + 3, 3 + nd, 3, "div_d2");

        // breakpoint, then step over it
        do_reset(); fill_prog();
        bp_en = 1'b1; bp_addr = 4'h3;
        run_to_halt(60);
        chk("bp_count1", 32'(count1), 32'd3); chk("bp_count2", 32'(count2), 32'd3);
        chk("bp_pc1", 32'(pc1), 32'd3);
        for (int i = 0; i < 3 && i < p1.size(); i++) chk("bp_trace1", 32'(p1[i]), 32'(i));
        pulse_step();
        chk("bpstep_count1", 32'(count1), 32'd4); chk("bpstep_count2", 32'(count2), 32'd4);
        chk("bpstep_pc1", 32'(pc1), 32'd4);       chk("bpstep_idle2", 32'(halted2), 32'd1);
        chk("bpstep_n1", 32'(p1.size()), 32'd4);
        if (p1.size() == 4) chk("bpstep_last1", 32'(p1[3]), 32'd3);

        // JMP to self ends the program
        do_reset(); fill_prog();
        rom_op[5] = JMP_IM; rom_imm[5] = 4'h5;
        run_to_halt(80);
        chk("loop_flag1", 32'(loop1), 32'd1);   chk("loop_flag2", 32'(loop2), 32'd1);
        chk("loop_count1", 32'(count1), 32'd6); chk("loop_count2", 32'(count2), 32'd6);
        chk("loop_pc1", 32'(pc1), 32'd5);
        run1 = 1'b1; run2 = 1'b1;
        tick(1);
        chk("loop_clear1", 32'(loop1), 32'd0);  chk("loop_clear2", 32'(loop2), 32'd0);
        run_to_halt(40);
        chk("loop_again1", 32'(loop1), 32'd1);  chk("loop_again_count1", 32'(count1), 32'd7);

        // halt during EXEC on d1 coincides with the last FETCH cycle on d2
        do_reset();
        c0 = cyc; run1 = 1'b1; run2 = 1'b1;
        tick(2);
        chk("halt_exec1", 32'(exec1), 32'd1); chk("halt_fetch2", 32'(state2), 32'd1);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0; run1 = 1'b0; run2 = 1'b0;
        chk("halt_idle1", 32'(state1), 32'd0); chk("halt_idle2", 32'(state2), 32'd0);
        tick(5);
        chk("halt_count1", 32'(count1), 32'd1); chk("halt_count2", 32'(count2), 32'd0);
        chk("halt_noexec2", 32'(q2.size()), 32'd0);

        // reset in WAIT
        do_reset();
        div_sel = 24'd4;
        run1 = 1'b1; run2 = 1'b1;
        tick(3);
        chk("rw_wait1", 32'(state1), 32'd3);
        rst = 1'b1;
        tick(1);
        chk("rw_exec1", 32'(exec1), 32'd0);   chk("rw_halt1", 32'(halted1), 32'd1);
        chk("rw_state1", 32'(state1), 32'd0); chk("rw_count1", 32'(count1), 32'd0);
        chk("rw_state2", 32'(state2), 32'd0); chk("rw_count2", 32'(count2), 32'd0);
        rst = 1'b0; run1 = 1'b0; run2 = 1'b0;
        tick(3);

        // counter wrap
        do_reset(); fill_prog();
        force u_d1.count_q = 16'hFFFE;
        tick(1);
        release u_d1.count_q;
        tick(1);
        chk("wrap_preset1", 32'(count1), 32'h0000FFFE);
        pulse_step();
        chk("wrap_ffff1", 32'(count1), 32'h0000FFFF);
        pulse_step();
        chk("wrap_zero1", 32'(count1), 32'd0);
        chk("wrap_count2", 32'(count2), 32'd2);

        chk("no_back_to_back", 32'(consec), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
